// File: rtl/ram_responder.sv
//------------------------------------------------------------------------------
// ram_responder : fixed-latency single-port 32-bit RAM slave with error flagging
// Revision 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_responder #(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(WORDS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          write_q, write_d;
  logic          bad_q, bad_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [31:0]   mem [WORDS];
  logic [31:0]   ram_dout;

  logic          accept;
  logic          complete;
  logic          misaligned;
  logic          out_of_range;
  logic [AW-1:0] req_idx;

  assign req_idx      = addr[AW+1:2];
  assign misaligned   = (addr[1:0] != 2'b00);
  assign out_of_range = (addr[31:AW+2] != '0);
  assign accept       = (state_q == IDLE) && (ren || wen);
  assign complete     = (state_q == WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    write_d = write_q;
    bad_d   = bad_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    if (state_q == IDLE) begin
      if (ren || wen) begin
        state_d = WAIT;
        cnt_d   = 4'(LATENCY - 1);
        idx_d   = req_idx;
        wdata_d = wdata;
        be_d    = byte_en;
        write_d = wen;
        bad_d   = misaligned || out_of_range;
        err_d   = (ren && wen) || misaligned || out_of_range;
      end
    end else begin
      if (cnt_q == 4'd0) begin
        state_d = IDLE;
        // ram_dout was captured at the acceptance edge and held since
        if (!write_q) rdata_d = bad_q ? 32'd0 : ram_dout;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end

    busy_d = (state_d == WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      write_q <= 1'b0;
      bad_q   <= 1'b0;
      rdata_q <= 32'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      write_q <= write_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Storage kept free of reset so it maps onto block RAM with a read-enabled output register.
  always_ff @(posedge clk) begin
    if (accept) ram_dout <= mem[req_idx];
    if (complete && write_q && !bad_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
//------------------------------------------------------------------------------
// tb_ram_responder : directed bench for ram_responder (LATENCY 2 and 3 instances)
// Revision 1.0     : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ren, wen;
  logic [31:0] addr, wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        busy, err;

  logic        ren_b, wen_b;
  logic [31:0] addr_b, wdata_b;
  logic [3:0]  byte_en_b;
  logic [31:0] rdata_b;
  logic        busy_b, err_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_b [3];

  always #5 clk = ~clk;

  ram_responder #(.WORDS(1024), .LATENCY(2)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .ren     (ren),
    .wen     (wen),
    .addr    (addr),
    .wdata   (wdata),
    .byte_en (byte_en),
    .rdata   (rdata),
    .busy    (busy),
    .err     (err)
  );

  ram_responder #(.WORDS(1024), .LATENCY(3)) u_dut_b (
    .clk     (clk),
    .reset   (reset),
    .ren     (ren_b),
    .wen     (wen_b),
    .addr    (addr_b),
    .wdata   (wdata_b),
    .byte_en (byte_en_b),
    .rdata   (rdata_b),
    .busy    (busy_b),
    .err     (err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One LATENCY=2 access on u_dut; inputs are scrambled while busy to show they are ignored.
  task automatic access(input string tag, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic exp_err);
    ren = r; wen = w; addr = a; wdata = d; byte_en = be;
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b0;
    addr = $urandom; wdata = $urandom; byte_en = 4'($urandom);
    check({tag, " busy c1"}, {31'd0, busy}, 32'd1);
    check({tag, " err acc"}, {31'd0, err}, {31'd0, exp_err});
    @(posedge clk); #1;
    check({tag, " busy c2"}, {31'd0, busy}, 32'd1);
    check({tag, " err c2"}, {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    check({tag, " busy end"}, {31'd0, busy}, 32'd0);
    check({tag, " err end"}, {31'd0, err}, 32'd0);
  endtask

  task automatic write_b(input logic [31:0] a, input logic [31:0] d);
    wen_b = 1'b1; addr_b = a; wdata_b = d; byte_en_b = 4'hF;
    @(posedge clk); #1;
    wen_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; byte_en = '0;
    ren_b = 1'b0; wen_b = 1'b0; addr_b = '0; wdata_b = '0; byte_en_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    reset = 1'b0;

    // Basic write then read
    access("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    check("wr10 rdata unchanged", rdata, 32'd0);
    access("rd10", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    check("rd10 rdata", rdata, 32'hDEADBEEF);

    // Partial byte-lane write
    access("wr20", 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
    access("wr20 be", 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    access("rd20", 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    check("rd20 rdata", rdata, 32'h11BB33DD);

    // Irregular reads
    access("rd12 mis", 1'b1, 1'b0, 32'h12, 32'h0, 4'h0, 1'b1);
    check("rd12 rdata", rdata, 32'd0);
    access("rd10 again", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    check("rd10 again rdata", rdata, 32'hDEADBEEF);
    access("rd1000 oor", 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1);
    check("rd1000 rdata", rdata, 32'd0);

    // Irregular writes must leave memory untouched
    access("wr11 mis", 1'b0, 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 1'b1);
    access("wr1010 oor", 1'b0, 1'b1, 32'h1010, 32'h01010101, 4'hF, 1'b1);
    access("wr10 be0", 1'b0, 1'b1, 32'h10, 32'h00000000, 4'h0, 1'b0);
    access("rd10 kept", 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    check("rd10 kept rdata", rdata, 32'hDEADBEEF);

    // ren and wen together act as a write
    access("rw8", 1'b1, 1'b1, 32'h8, 32'h5, 4'hF, 1'b1);
    check("rw8 rdata unchanged", rdata, 32'hDEADBEEF);
    access("rd8", 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0);
    check("rd8 rdata", rdata, 32'h5);

    // Reset during a pending write
    access("wr4 pre", 1'b0, 1'b1, 32'h4, 32'h12345678, 4'hF, 1'b0);
    access("rd4 pre", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    check("rd4 pre rdata", rdata, 32'h12345678);
    wen = 1'b1; addr = 32'h4; wdata = 32'h77; byte_en = 4'hF;
    @(posedge clk); #1;
    wen = 1'b0;
    check("rst wr busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst async busy", {31'd0, busy}, 32'd0);
    check("rst async rdata", rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    access("rd4 post", 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    check("rd4 post rdata", rdata, 32'h12345678);

    // LATENCY=3 instance: ren held high with a new address every cycle
    for (int i = 0; i < 3; i++) begin
      model_b[i] = 32'hB0B00000 + 32'(i * 17 + 1);
      write_b(32'(4 * i), model_b[i]);
    end
    ren_b = 1'b1;
    for (int c = 0; c < 16; c++) begin
      addr_b = 32'(4 * (c % 3));
      @(posedge clk); #1;
      check($sformatf("b err c%0d", c), {31'd0, err_b}, 32'd0);
      if ((c % 4) == 3) begin
        check($sformatf("b busy c%0d", c), {31'd0, busy_b}, 32'd0);
        check($sformatf("b rdata c%0d", c), rdata_b, model_b[(c - 3) % 3]);
      end else begin
        check($sformatf("b busy c%0d", c), {31'd0, busy_b}, 32'd1);
      end
    end
    ren_b = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
